// File: rtl/mio_arbiter.sv
// rtl/mio_arbiter.sv - two-master arbiter for the shared memory/IO port
// Optional build macro: MIO_ARB_CPU_PRIORITY_EN (CPU wins every tie in IDLE;
// round-robin between the two masters when undefined).
module mio_arbiter #(
    parameter int AW      = 32,
    parameter int DW      = 32,
    parameter int MEM_LAT = 2
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          m0_req,
    input  logic          m0_we,
    input  logic [AW-1:0] m0_addr,
    input  logic [DW-1:0] m0_wdata,
    output logic [DW-1:0] m0_rdata,
    output logic          m0_ready,
    input  logic          m1_req,
    input  logic          m1_we,
    input  logic [AW-1:0] m1_addr,
    input  logic [DW-1:0] m1_wdata,
    output logic [DW-1:0] m1_rdata,
    output logic          m1_ready,
    output logic          mem_en,
    output logic          mem_we,
    output logic [AW-1:0] mem_addr,
    output logic [DW-1:0] mem_wdata,
    input  logic [DW-1:0] mem_rdata,
    output logic [1:0]    grant,
    output logic [1:0]    state_out
);

    typedef enum logic [1:0] {
        ST_IDLE   = 2'b00,
        ST_ACCESS = 2'b01,
        ST_DONE   = 2'b10
    } state_t;

    // Counter reload: lat_cnt counts down to zero over MEM_LAT enabled cycles.
    localparam logic [3:0] LAT_LOAD = 4'(MEM_LAT - 1);

    state_t        r_state;
    state_t        w_state_nxt;
    logic [3:0]    r_lat_cnt;
    logic [3:0]    w_lat_cnt_nxt;
    logic          r_last_grant;     // 0 = master 0 served last, 1 = master 1
    logic          w_last_grant_nxt;

    logic          r_mem_en;
    logic          r_mem_we;
    logic [AW-1:0] r_mem_addr;
    logic [DW-1:0] r_mem_wdata;
    logic [1:0]    r_grant;
    logic          r_m0_ready;
    logic          r_m1_ready;
    logic [DW-1:0] r_m0_rdata;
    logic [DW-1:0] r_m1_rdata;

    logic          w_mem_en_nxt;
    logic          w_mem_we_nxt;
    logic [AW-1:0] w_mem_addr_nxt;
    logic [DW-1:0] w_mem_wdata_nxt;
    logic [1:0]    w_grant_nxt;
    logic          w_m0_ready_nxt;
    logic          w_m1_ready_nxt;
    logic [DW-1:0] w_m0_rdata_nxt;
    logic [DW-1:0] w_m1_rdata_nxt;

    logic          w_req_any;
    logic          w_pick_m1;

    assign w_req_any = m0_req | m1_req;

`ifdef MIO_ARB_CPU_PRIORITY_EN
    // Fixed priority: master 1 only wins when the CPU is not asking.
    always_comb begin
        w_pick_m1 = ~m0_req & m1_req;
    end
`else
    // Round-robin: on a tie, serve whichever master did not go last.
    always_comb begin
        w_pick_m1 = 1'b0;
        if (m0_req && m1_req) begin
            w_pick_m1 = ~r_last_grant;
        end else begin
            w_pick_m1 = m1_req;
        end
    end
`endif

    // State register.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Next-state and next-output decode; every output is registered below.
    always_comb begin
        w_state_nxt      = r_state;
        w_lat_cnt_nxt    = r_lat_cnt;
        w_last_grant_nxt = r_last_grant;
        w_mem_en_nxt     = r_mem_en;
        w_mem_we_nxt     = r_mem_we;
        w_mem_addr_nxt   = r_mem_addr;
        w_mem_wdata_nxt  = r_mem_wdata;
        w_grant_nxt      = r_grant;
        w_m0_ready_nxt   = 1'b0;
        w_m1_ready_nxt   = 1'b0;
        w_m0_rdata_nxt   = r_m0_rdata;
        w_m1_rdata_nxt   = r_m1_rdata;

        case (r_state)
            ST_IDLE: begin
                w_mem_en_nxt = 1'b0;
                w_mem_we_nxt = 1'b0;
                w_grant_nxt  = 2'b00;
                if (w_req_any) begin
                    // Latch the winner's command so later changes on its
                    // request lines cannot disturb the access in flight.
                    w_mem_en_nxt     = 1'b1;
                    w_lat_cnt_nxt    = LAT_LOAD;
                    w_last_grant_nxt = w_pick_m1;
                    w_state_nxt      = ST_ACCESS;
                    if (w_pick_m1) begin
                        w_mem_we_nxt    = m1_we;
                        w_mem_addr_nxt  = m1_addr;
                        w_mem_wdata_nxt = m1_wdata;
                        w_grant_nxt     = 2'b10;
                    end else begin
                        w_mem_we_nxt    = m0_we;
                        w_mem_addr_nxt  = m0_addr;
                        w_mem_wdata_nxt = m0_wdata;
                        w_grant_nxt     = 2'b01;
                    end
                end
            end

            ST_ACCESS: begin
                if (r_lat_cnt != 4'd0) begin
                    w_lat_cnt_nxt = r_lat_cnt - 4'd1;
                end else begin
                    // Last enabled cycle: mem_rdata is valid right now.
                    if (r_grant[1]) begin
                        w_m1_ready_nxt = 1'b1;
                        if (!r_mem_we) begin
                            w_m1_rdata_nxt = mem_rdata;
                        end
                    end else begin
                        w_m0_ready_nxt = 1'b1;
                        if (!r_mem_we) begin
                            w_m0_rdata_nxt = mem_rdata;
                        end
                    end
                    w_mem_en_nxt = 1'b0;
                    w_mem_we_nxt = 1'b0;
                    w_grant_nxt  = 2'b00;
                    w_state_nxt  = ST_DONE;
                end
            end

            ST_DONE: begin
                // Bubble so a master that just saw ready can drop its request
                // before IDLE samples again.
                w_state_nxt = ST_IDLE;
            end

            default: begin
                w_state_nxt  = ST_IDLE;
                w_mem_en_nxt = 1'b0;
                w_mem_we_nxt = 1'b0;
                w_grant_nxt  = 2'b00;
            end
        endcase
    end

    // Registered datapath, counter and port outputs.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_lat_cnt    <= 4'd0;
            r_last_grant <= 1'b1;
            r_mem_en     <= 1'b0;
            r_mem_we     <= 1'b0;
            r_mem_addr   <= '0;
            r_mem_wdata  <= '0;
            r_grant      <= 2'b00;
            r_m0_ready   <= 1'b0;
            r_m1_ready   <= 1'b0;
            r_m0_rdata   <= '0;
            r_m1_rdata   <= '0;
        end else begin
            r_lat_cnt    <= w_lat_cnt_nxt;
            r_last_grant <= w_last_grant_nxt;
            r_mem_en     <= w_mem_en_nxt;
            r_mem_we     <= w_mem_we_nxt;
            r_mem_addr   <= w_mem_addr_nxt;
            r_mem_wdata  <= w_mem_wdata_nxt;
            r_grant      <= w_grant_nxt;
            r_m0_ready   <= w_m0_ready_nxt;
            r_m1_ready   <= w_m1_ready_nxt;
            r_m0_rdata   <= w_m0_rdata_nxt;
            r_m1_rdata   <= w_m1_rdata_nxt;
        end
    end

    assign mem_en    = r_mem_en;
    assign mem_we    = r_mem_we;
    assign mem_addr  = r_mem_addr;
    assign mem_wdata = r_mem_wdata;
    assign grant     = r_grant;
    assign m0_ready  = r_m0_ready;
    assign m1_ready  = r_m1_ready;
    assign m0_rdata  = r_m0_rdata;
    assign m1_rdata  = r_m1_rdata;
    assign state_out = r_state;

endmodule

// File: tb/tb_mio_arbiter.sv
// tb/tb_mio_arbiter.sv - scoreboard bench for mio_arbiter
module tb_mio_arbiter;

    localparam int MEM_LAT = 2;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        m0_req = 1'b0, m0_we = 1'b0;
    logic [31:0] m0_addr = '0, m0_wdata = '0;
    logic [31:0] m0_rdata;
    logic        m0_ready;
    logic        m1_req = 1'b0, m1_we = 1'b0;
    logic [31:0] m1_addr = '0, m1_wdata = '0;
    logic [31:0] m1_rdata;
    logic        m1_ready;
    logic        mem_en, mem_we;
    logic [31:0] mem_addr, mem_wdata;
    logic [31:0] mem_rdata = 32'hBAD0_BAD0;
    logic [1:0]  grant, state_out;

    mio_arbiter #(.AW(32), .DW(32), .MEM_LAT(MEM_LAT)) dut (
        .clk(clk), .reset(reset),
        .m0_req(m0_req), .m0_we(m0_we), .m0_addr(m0_addr), .m0_wdata(m0_wdata),
        .m0_rdata(m0_rdata), .m0_ready(m0_ready),
        .m1_req(m1_req), .m1_we(m1_we), .m1_addr(m1_addr), .m1_wdata(m1_wdata),
        .m1_rdata(m1_rdata), .m1_ready(m1_ready),
        .mem_en(mem_en), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
        .mem_rdata(mem_rdata), .grant(grant), .state_out(state_out)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [1:0]  g;
        logic        we;
        logic [31:0] addr;
        logic [31:0] wdata;
    } grec_t;

    typedef struct {
        int          m;
        logic [31:0] rdata;
    } rrec_t;

    grec_t exp_g[$];
    rrec_t exp_r[$];

    int total = 0;
    int bad   = 0;
    int cyc   = 0;
    bit spacing_on = 1'b0;
    int last_rdy_cyc = -1;

    function automatic logic [31:0] mem_model(logic [31:0] a);
        if (a == 32'h0000_0100) return 32'hDEAD_BEEF;
        return {a[15:0], ~a[15:0]};
    endfunction

    task automatic chk(string name, logic [63:0] act, logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s actual=%h expected=%h", name, act, exp);
        end
    endtask

    task automatic push_g(logic [1:0] g, logic we, logic [31:0] a, logic [31:0] d);
        grec_t r;
        r.g = g; r.we = we; r.addr = a; r.wdata = d;
        exp_g.push_back(r);
    endtask

    task automatic push_r(int m, logic [31:0] d);
        rrec_t r;
        r.m = m; r.rdata = d;
        exp_r.push_back(r);
    endtask

    // Waits for the given master's ready; reports posedges elapsed.
    task automatic wait_ready(input int m, output int n);
        n = 0;
        for (int k = 0; k < 40; k++) begin
            @(posedge clk);
            n++;
            @(negedge clk);
            if ((m == 0 && m0_ready) || (m == 1 && m1_ready)) return;
        end
        total++; bad++;
        $display("FAIL wait_ready_m%0d timeout after %0d cycles", m, n);
    endtask

    task automatic wait_mem_en();
        for (int k = 0; k < 40; k++) begin
            @(negedge clk);
            if (mem_en) return;
        end
        total++; bad++;
        $display("FAIL wait_mem_en timeout");
    endtask

    task automatic apply_reset();
        @(negedge clk); #1 reset = 1'b1;
        repeat (2) @(negedge clk);
        #1 reset = 1'b0;
    endtask

    // Memory model, grant/port monitor and ready scoreboard.
    initial begin : monitor
        grec_t g_rec;
        rrec_t r_rec;
        bit    g_act = 1'b0;
        int    en_cycles = 0;
        int    en_seen = 0;
        logic [1:0]  prev_grant = 2'b00;
        logic        prev_rdy = 1'b0;
        logic [31:0] model0 = '0, model1 = '0;
        forever begin
            @(negedge clk);
            cyc++;
            if (reset) begin
                g_act = 1'b0; prev_grant = 2'b00; prev_rdy = 1'b0;
                model0 = '0; model1 = '0; en_seen = 0;
                mem_rdata = 32'hBAD0_BAD0;
                continue;
            end
            if (grant != 2'b00 && prev_grant == 2'b00) begin
                if (exp_g.size() == 0) begin
                    total++; bad++;
                    $display("FAIL unexpected_grant actual=%b required=none", grant);
                end else begin
                    g_rec = exp_g.pop_front();
                    chk("grant_owner", 64'(grant), 64'(g_rec.g));
                    g_act = 1'b1;
                    en_cycles = 0;
                end
            end
            if (g_act && grant != 2'b00) begin
                en_cycles++;
                chk("mem_en_held", 64'(mem_en), 64'd1);
                chk("mem_we_latched", 64'(mem_we), 64'(g_rec.we));
                chk("mem_addr_latched", 64'(mem_addr), 64'(g_rec.addr));
                chk("mem_wdata_latched", 64'(mem_wdata), 64'(g_rec.wdata));
            end
            if (g_act && grant == 2'b00 && prev_grant != 2'b00) begin
                chk("mem_en_cycles", 64'(en_cycles), 64'(MEM_LAT));
                chk("mem_en_dropped", 64'(mem_en), 64'd0);
                g_act = 1'b0;
            end
            if (m0_ready || m1_ready) begin
                chk("ready_onehot", 64'(m0_ready & m1_ready), 64'd0);
                chk("ready_single_pulse", 64'(prev_rdy), 64'd0);
                if (exp_r.size() == 0) begin
                    total++; bad++;
                    $display("FAIL unexpected_ready actual=m0:%b m1:%b required=none", m0_ready, m1_ready);
                end else begin
                    r_rec = exp_r.pop_front();
                    chk("ready_master", 64'(m1_ready ? 1 : 0), 64'(r_rec.m));
                    if (m1_ready) begin
                        chk("m1_rdata", 64'(m1_rdata), 64'(r_rec.rdata));
                        chk("m0_rdata_hold", 64'(m0_rdata), 64'(model0));
                        model1 = r_rec.rdata;
                    end else begin
                        chk("m0_rdata", 64'(m0_rdata), 64'(r_rec.rdata));
                        chk("m1_rdata_hold", 64'(m1_rdata), 64'(model1));
                        model0 = r_rec.rdata;
                    end
                    chk("state_done_at_ready", 64'(state_out), 64'd2);
                    chk("grant_clear_at_ready", 64'(grant), 64'd0);
                    if (spacing_on && last_rdy_cyc >= 0)
                        chk("ready_spacing", 64'(cyc - last_rdy_cyc), 64'(MEM_LAT + 2));
                    last_rdy_cyc = cyc;
                end
            end
            prev_rdy = m0_ready | m1_ready;
            prev_grant = grant;
            // Read data is only meaningful in the last enabled cycle.
            en_seen = mem_en ? en_seen + 1 : 0;
            mem_rdata = (mem_en && en_seen == MEM_LAT) ? mem_model(mem_addr) : 32'hBAD0_BAD0;
        end
    end

    initial begin : watchdog
        #200000;
        $display("FAIL watchdog timeout");
        $fatal(1, "watchdog");
    end

    initial begin : stimulus
        int c;
        apply_reset();
        @(negedge clk);
        chk("rst_state", 64'(state_out), 64'd0);
        chk("rst_grant", 64'(grant), 64'd0);
        chk("rst_mem_en", 64'(mem_en), 64'd0);
        chk("rst_mem_we", 64'(mem_we), 64'd0);
        chk("rst_mem_addr", 64'(mem_addr), 64'd0);
        chk("rst_mem_wdata", 64'(mem_wdata), 64'd0);
        chk("rst_m0_ready", 64'(m0_ready), 64'd0);
        chk("rst_m1_ready", 64'(m1_ready), 64'd0);
        chk("rst_m0_rdata", 64'(m0_rdata), 64'd0);
        chk("rst_m1_rdata", 64'(m1_rdata), 64'd0);

        // Single CPU read.
        #1;
        push_g(2'b01, 1'b0, 32'h100, 32'h0);
        push_r(0, 32'hDEAD_BEEF);
        m0_we = 1'b0; m0_addr = 32'h100; m0_wdata = 32'h0; m0_req = 1'b1;
        wait_ready(0, c);
        chk("cpu_read_latency", 64'(c), 64'(MEM_LAT + 1));
        #1 m0_req = 1'b0;
        repeat (2) @(negedge clk);

        // Master 1 write: its rdata stays at its reset value.
        #1;
        push_g(2'b10, 1'b1, 32'h200, 32'h1234_5678);
        push_r(1, 32'h0);
        m1_we = 1'b1; m1_addr = 32'h200; m1_wdata = 32'h1234_5678; m1_req = 1'b1;
        wait_ready(1, c);
        chk("m1_write_latency", 64'(c), 64'(MEM_LAT + 1));
        #1 m1_req = 1'b0; m1_we = 1'b0;
        repeat (2) @(negedge clk);

        // Continuous dual requests from reset, three reads per master.
        apply_reset();
        @(negedge clk); #1;
`ifdef MIO_ARB_CPU_PRIORITY_EN
        for (int i = 0; i < 3; i++) begin
            push_g(2'b01, 1'b0, 32'h10 + 32'(4 * i), 32'hC0DE_0000 + 32'(i));
            push_r(0, mem_model(32'h10 + 32'(4 * i)));
        end
        for (int i = 0; i < 3; i++) begin
            push_g(2'b10, 1'b0, 32'h300 + 32'(4 * i), 32'hD00D_0000 + 32'(i));
            push_r(1, mem_model(32'h300 + 32'(4 * i)));
        end
`else
        for (int i = 0; i < 3; i++) begin
            push_g(2'b01, 1'b0, 32'h10 + 32'(4 * i), 32'hC0DE_0000 + 32'(i));
            push_r(0, mem_model(32'h10 + 32'(4 * i)));
            push_g(2'b10, 1'b0, 32'h300 + 32'(4 * i), 32'hD00D_0000 + 32'(i));
            push_r(1, mem_model(32'h300 + 32'(4 * i)));
        end
`endif
        spacing_on = 1'b1;
        last_rdy_cyc = -1;
        fork
            begin
                int c0;
                for (int i = 0; i < 3; i++) begin
                    m0_addr = 32'h10 + 32'(4 * i);
                    m0_wdata = 32'hC0DE_0000 + 32'(i);
                    m0_req = 1'b1;
                    wait_ready(0, c0);
                    #1;
                end
                m0_req = 1'b0;
            end
            begin
                int c1;
                for (int i = 0; i < 3; i++) begin
                    m1_addr = 32'h300 + 32'(4 * i);
                    m1_wdata = 32'hD00D_0000 + 32'(i);
                    m1_req = 1'b1;
                    wait_ready(1, c1);
                    #1;
                end
                m1_req = 1'b0;
            end
        join
        spacing_on = 1'b0;
        repeat (2) @(negedge clk);

        // Reset during the first ACCESS cycle aborts without a ready pulse.
        #1;
        push_g(2'b01, 1'b0, 32'h40, 32'h0);
        m0_addr = 32'h40; m0_wdata = 32'h0; m0_req = 1'b1;
        wait_mem_en();
        #1 reset = 1'b1;
        #1;
        chk("abort_mem_en_async", 64'(mem_en), 64'd0);
        chk("abort_grant_async", 64'(grant), 64'd0);
        @(negedge clk);
        chk("abort_mem_en", 64'(mem_en), 64'd0);
        chk("abort_grant", 64'(grant), 64'd0);
        chk("abort_m0_ready", 64'(m0_ready), 64'd0);
        chk("abort_state", 64'(state_out), 64'd0);
        #1 reset = 1'b0;
        push_g(2'b01, 1'b0, 32'h40, 32'h0);
        push_r(0, mem_model(32'h40));
        wait_ready(0, c);
        chk("post_abort_latency", 64'(c), 64'(MEM_LAT + 1));
        #1 m0_req = 1'b0;
        repeat (2) @(negedge clk);

        // CPU drops its request and changes its command mid-access.
        #1;
        push_g(2'b01, 1'b0, 32'h500, 32'h0);
        push_r(0, mem_model(32'h500));
        push_g(2'b10, 1'b0, 32'h600, 32'h0);
        push_r(1, mem_model(32'h600));
        spacing_on = 1'b1;
        last_rdy_cyc = -1;
        m0_addr = 32'h500; m0_we = 1'b0; m0_req = 1'b1;
        wait_mem_en();
        #1;
        m0_req = 1'b0; m0_addr = 32'h5FC; m0_we = 1'b1;
        m1_addr = 32'h600; m1_we = 1'b0; m1_wdata = 32'h0; m1_req = 1'b1;
        wait_ready(0, c);
        wait_ready(1, c);
        chk("m1_after_bubble_latency", 64'(c), 64'(MEM_LAT + 2));
        #1 m1_req = 1'b0; m0_we = 1'b0;
        spacing_on = 1'b0;
        repeat (6) @(negedge clk);

        chk("grant_queue_drained", 64'(exp_g.size()), 64'd0);
        chk("ready_queue_drained", 64'(exp_r.size()), 64'd0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
